// File: rtl/text_overlay_draw.sv
// text_overlay_draw: rasterises a 32x8 character grid (8x16 glyphs) onto the
// VGA pixel stream. The grid address goes out on char_xy. The character ROM
// answers one clock later, and the font ROM answers one clock after that.
// Every timing signal is delayed by the same 4 clocks so it stays aligned
// with rgb_out.
// Optional build macro TEXT_BLINK_EN adds a frame-counted blink of the text.
module text_overlay_draw #(
   parameter logic [10:0] X_POS      = 11'd384,
   parameter logic [10:0] Y_POS      = 11'd320,
   parameter logic [11:0] TEXT_COLOR = 12'hFFF
`ifdef TEXT_BLINK_EN
   ,
   parameter logic [5:0]  BLINK_PERIOD = 6'd30
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [7:0]  char_xy,
   input  logic [6:0]  char_code,
   output logic [10:0] char_line_addr,
   input  logic [7:0]  char_line_pixels,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   // Timing and colour travel together through the pipeline as one bundle.
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } meta_t;

   // The box bounds are computed 12 bits wide so a box near the right or
   // bottom edge clips instead of wrapping back to column or row 0.
   localparam logic [11:0] X_END = {1'b0, X_POS} + 12'd255;
   localparam logic [11:0] Y_END = {1'b0, Y_POS} + 12'd127;

   logic        in_box;
   logic        draw_en;
   logic [7:0]  rel_x;
   logic [6:0]  rel_y;
   logic        pix;
   meta_t       meta_in;

   meta_t       meta_d1, meta_d2, meta_d3;
   logic [2:0]  rel_x_d1, rel_x_d2, rel_x_d3;
   logic [3:0]  rel_y_d1, rel_y_d2;
   logic        in_box_d1, in_box_d2, in_box_d3;

   // Only the low bits of the offsets are used. Wrap-around subtraction on
   // those bits gives the same result as on the full 11-bit counters.
   assign rel_x  = hcount_in[7:0] - X_POS[7:0];
   assign rel_y  = vcount_in[6:0] - Y_POS[6:0];
   assign in_box = (hcount_in >= X_POS) && ({1'b0, hcount_in} <= X_END) &&
                   (vcount_in >= Y_POS) && ({1'b0, vcount_in} <= Y_END);

   assign meta_in = '{hcount: hcount_in, vcount: vcount_in,
                      hsync: hsync_in, vsync: vsync_in,
                      hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

`ifdef TEXT_BLINK_EN
   logic [5:0] frame_cnt;
   logic       vsync_prev;
   logic       visible;

   // Count frames on vsync rising edges and toggle visibility every
   // BLINK_PERIOD frames.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt  <= 6'd0;
         vsync_prev <= 1'b0;
         visible    <= 1'b1;
      end else begin
         vsync_prev <= vsync_in;
         if (vsync_in && !vsync_prev) begin
            if (frame_cnt == BLINK_PERIOD - 6'd1) begin
               frame_cnt <= 6'd0;
               visible   <= ~visible;
            end else begin
               frame_cnt <= frame_cnt + 6'd1;
            end
         end
      end
   end

   assign draw_en = in_box && visible;
`else
   assign draw_en = in_box;
`endif

   // Stage 1: issue the grid address and capture offsets and timing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         char_xy   <= 8'd0;
         rel_x_d1  <= 3'd0;
         rel_y_d1  <= 4'd0;
         in_box_d1 <= 1'b0;
         meta_d1   <= '0;
      end else begin
         char_xy   <= {rel_x[7:3], rel_y[6:4]};
         rel_x_d1  <= rel_x[2:0];
         rel_y_d1  <= rel_y[3:0];
         in_box_d1 <= draw_en;
         meta_d1   <= meta_in;
      end
   end

   // Stages 2 and 3: carry the metadata while the two ROM reads complete.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rel_x_d2  <= 3'd0;
         rel_y_d2  <= 4'd0;
         in_box_d2 <= 1'b0;
         meta_d2   <= '0;
         rel_x_d3  <= 3'd0;
         in_box_d3 <= 1'b0;
         meta_d3   <= '0;
      end else begin
         rel_x_d2  <= rel_x_d1;
         rel_y_d2  <= rel_y_d1;
         in_box_d2 <= in_box_d1;
         meta_d2   <= meta_d1;
         rel_x_d3  <= rel_x_d2;
         in_box_d3 <= in_box_d2;
         meta_d3   <= meta_d2;
      end
   end

   assign char_line_addr = {char_code, rel_y_d2};

   // Bit 7 of the font row is the leftmost pixel of the glyph.
   assign pix = char_line_pixels[3'd7 - rel_x_d3];

   // Stage 4: composite the glyph pixel over the upstream colour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_out <= 11'd0;
         vcount_out <= 11'd0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= 12'd0;
      end else begin
         hcount_out <= meta_d3.hcount;
         vcount_out <= meta_d3.vcount;
         hsync_out  <= meta_d3.hsync;
         vsync_out  <= meta_d3.vsync;
         hblnk_out  <= meta_d3.hblnk;
         vblnk_out  <= meta_d3.vblnk;
         rgb_out    <= (in_box_d3 && pix && !meta_d3.hblnk && !meta_d3.vblnk)
                       ? TEXT_COLOR : meta_d3.rgb;
      end
   end

endmodule

// File: tb/tb_text_overlay_draw.sv
// Testbench for text_overlay_draw. Model character and font ROMs answer the
// DUT's addresses. A frame-level reference model predicts every output.
module tb_text_overlay_draw;

   localparam logic [10:0] XP = 11'd384;
   localparam logic [10:0] YP = 11'd320;
   localparam logic [11:0] TC = 12'hFFF;
`ifdef TEXT_BLINK_EN
   localparam int BP = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [7:0]  char_xy;
   logic [6:0]  char_code = '0;
   logic [10:0] char_line_addr;
   logic [7:0]  char_line_pixels = '0;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   int total = 0;
   int bad = 0;

   logic [6:0] cmem [256];
   logic [7:0] fmem [2048];

   text_overlay_draw #(
      .X_POS(XP), .Y_POS(YP), .TEXT_COLOR(TC)
`ifdef TEXT_BLINK_EN
      , .BLINK_PERIOD(6'd2)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .char_xy(char_xy), .char_code(char_code),
      .char_line_addr(char_line_addr), .char_line_pixels(char_line_pixels),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   // Free-running pixel clock.
   always #5 clk = ~clk;

   // Registered ROM models, each with one clock of read latency.
   always @(posedge clk) begin
      char_code        <= cmem[char_xy];
      char_line_pixels <= fmem[char_line_addr];
   end

   typedef struct packed {
      logic [11:0] rgb;
      logic [10:0] h;
      logic [10:0] v;
      logic        hs, vs, hb, vb;
   } vec_t;

   // Grid cell index (column * 8 + row) of a pixel, from wrapped offsets.
   function automatic int gridAddr(input logic [10:0] h, input logic [10:0] v);
      int rx, ry;
      rx = (int'(h) - int'(XP)) & 2047;
      ry = (int'(v) - int'(YP)) & 2047;
      return ((rx / 8) % 32) * 8 + (ry / 16) % 8;
   endfunction

   // Reference: the colour a pixel must show, from the glyph pixel under it.
   function automatic vec_t modelPixel(input logic [10:0] h, input logic [10:0] v,
                                       input logic [11:0] rgb, input logic hs,
                                       input logic vs, input logic hb,
                                       input logic vb, input bit vis);
      vec_t r;
      int rx, ry, code;
      bit box;
      logic [7:0] row;
      rx  = (int'(h) - int'(XP)) & 2047;
      ry  = (int'(v) - int'(YP)) & 2047;
      box = (int'(h) >= int'(XP)) && (int'(h) <= int'(XP) + 255) &&
            (int'(v) >= int'(YP)) && (int'(v) <= int'(YP) + 127);
      code = int'(cmem[gridAddr(h, v)]);
      row  = fmem[code * 16 + ry % 16];
      r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.hb = hb; r.vb = vb;
      r.rgb = (box && vis && row[7 - rx % 8] && !hb && !vb) ? TC : rgb;
      return r;
   endfunction

   vec_t       pipe[$];
   vec_t       cur_exp = '0;
   logic [7:0] exp_xy = '0;
   int         vs_pulses = 0;
   bit         vs_prev = 1'b0;

   // Reference pipeline: outputs after each edge reflect the input taken
   // three edges earlier.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            pipe = {};
            repeat (3) pipe.push_back('0);
            cur_exp   = '0;
            exp_xy    = '0;
            vs_pulses = 0;
            vs_prev   = 1'b0;
         end else begin
            bit vis;
            vis = 1'b1;
`ifdef TEXT_BLINK_EN
            vis = ((vs_pulses / BP) % 2) == 0;
`endif
            pipe.push_back(modelPixel(hcount_in, vcount_in, rgb_in, hsync_in,
                                      vsync_in, hblnk_in, vblnk_in, vis));
            cur_exp = pipe.pop_front();
            exp_xy  = 8'(gridAddr(hcount_in, vcount_in));
            if (vsync_in && !vs_prev) vs_pulses++;
            vs_prev = vsync_in;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one input vector at the next falling edge and hold it for n cycles.
   task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                                input logic [11:0] rgb, input logic hs,
                                input logic vs, input logic hb, input logic vb,
                                input int n);
      @(negedge clk);
      hcount_in = h; vcount_in = v; rgb_in = rgb;
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
      repeat (n - 1) @(negedge clk);
   endtask

   // Per-cycle comparison against the reference, on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            checkOutput("reset_outs", {rgb_out, hcount_out, vcount_out, hsync_out,
                        vsync_out, hblnk_out, vblnk_out, char_xy}, 64'd0);
         end else begin
            checkOutput("pipe_rgb", rgb_out, cur_exp.rgb);
            checkOutput("pipe_timing",
                        {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
                        {cur_exp.h, cur_exp.v, cur_exp.hs, cur_exp.vs, cur_exp.hb, cur_exp.vb});
            checkOutput("char_xy", char_xy, exp_xy);
         end
      end
   end

   initial begin
      for (int a = 0; a < 256; a++) cmem[a] = 7'(a);
      for (int a = 0; a < 2048; a++) fmem[a] = 8'(a * 37 + 11);
      cmem[8'h00] = 7'h10;
      cmem[8'h12] = 7'h52;
      cmem[8'h07] = 7'h20;
      cmem[8'hFF] = 7'h20;
      fmem[11'h100] = 8'h80;
      fmem[11'h101] = 8'h01;
      for (int r = 0; r < 16; r++) fmem[11'h200 + r] = 8'hFF;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Pass-through outside the box with the timing held constant.
      applyStimulus(11'd100, 11'd50, 12'hABC, 1'b1, 1'b0, 1'b1, 1'b0, 6);
      checkOutput("pass_rgb", rgb_out, 12'hABC);
      checkOutput("pass_hcount", hcount_out, 11'd100);
      checkOutput("pass_vcount", vcount_out, 11'd50);
      checkOutput("pass_syncs", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 4'b1010);

      // Latency: the first of four back-to-back vectors appears on the 4th edge.
      applyStimulus(11'd7, 11'd9, 12'h5A5, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      applyStimulus(11'd8, 11'd9, 12'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(11'd9, 11'd9, 12'h222, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      applyStimulus(11'd10, 11'd9, 12'h333, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      @(negedge clk);
      checkOutput("lat4_rgb", rgb_out, 12'h5A5);
      checkOutput("lat4_hcount", hcount_out, 11'd7);
      checkOutput("lat4_vblnk", vblnk_out, 1'b1);

      // Addressing.
      applyStimulus(11'(XP + 17), 11'(YP + 35), 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      @(negedge clk);
      checkOutput("addr_char_xy", char_xy, 8'h12);
      @(negedge clk);
      checkOutput("addr_line", char_line_addr, 11'h523);

      // Pixel select: row 0 of cell 0 is 8'h80, row 1 is 8'h01.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(11'(XP + k), YP, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 6);
         checkOutput("pix80", rgb_out, (k == 0) ? TC : 12'h123);
      end
      for (int k = 0; k < 8; k++) begin
         applyStimulus(11'(XP + k), 11'(YP + 1), 12'h456, 1'b0, 1'b0, 1'b0, 1'b0, 6);
         checkOutput("pix01", rgb_out, (k == 7) ? TC : 12'h456);
      end

      // Box edges on a solid glyph row.
      applyStimulus(11'(XP - 1), 11'(YP + 127), 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      checkOutput("edge_left_out", rgb_out, 12'h123);
      applyStimulus(XP, 11'(YP + 127), 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      checkOutput("edge_left_in", rgb_out, TC);
      applyStimulus(11'(XP + 255), 11'(YP + 127), 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      checkOutput("edge_right_in", rgb_out, TC);
      applyStimulus(11'(XP + 256), 11'(YP + 127), 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      checkOutput("edge_right_out", rgb_out, 12'h123);
      applyStimulus(XP, 11'(YP + 128), 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      checkOutput("edge_bottom_out", rgb_out, 12'h123);
      applyStimulus(XP, 11'(YP + 127), 12'h123, 1'b0, 1'b0, 1'b1, 1'b0, 6);
      checkOutput("hblnk_mask", rgb_out, 12'h123);
      applyStimulus(XP, 11'(YP + 127), 12'h123, 1'b0, 1'b0, 1'b0, 1'b1, 6);
      checkOutput("vblnk_mask", rgb_out, 12'h123);

      // Streams checked cycle by cycle against the reference.
      for (int i = 0; i < 40; i++)
         applyStimulus(11'(i * 5), 11'd10, 12'(i * 101), 1'(i % 2), 1'b0,
                       1'((i / 4) % 2), 1'((i / 8) % 2), 1);
      for (int h = 370; h <= 660; h++)
         applyStimulus(11'(h), 11'(YP + 35), 12'(h * 7), 1'b0, 1'b0,
                       1'(h >= 650), 1'b0, 1);
      for (int v = int'(YP) - 3; v <= int'(YP) + 131; v++)
         applyStimulus(11'(XP + 250), 11'(v), 12'h0C0, 1'b0, 1'b0, 1'b0,
                       1'(v == int'(YP) + 60), 1);
      for (int i = 0; i < 200; i++)
         applyStimulus(11'(int'(XP) + (i * 13) % 260), 11'(int'(YP) + (i * 7) % 135),
                       12'(i * 29), 1'b0, 1'b0, 1'b0, 1'b0, 1);

      // Asynchronous reset in mid-line, then the 4-edge refill.
      applyStimulus(XP, 11'(YP + 127), 12'h321, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      checkOutput("pre_rst_rgb", rgb_out, TC);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("async_rst", {rgb_out, hcount_out, vcount_out, hsync_out,
                     vsync_out, hblnk_out, vblnk_out, char_xy}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_edge3", {rgb_out, hcount_out}, 64'd0);
      @(negedge clk);
      checkOutput("rst_edge4_rgb", rgb_out, TC);
      checkOutput("rst_edge4_hcount", hcount_out, XP);

`ifdef TEXT_BLINK_EN
      // Blink: visible in frames 0 and 1, hidden after the second vsync.
      for (int f = 0; f < 3; f++) begin
         applyStimulus(XP, 11'(YP + 127), 12'h0A0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
         checkOutput("blink_frame", rgb_out, (f < 2) ? TC : 12'h0A0);
         applyStimulus(11'd5, 11'd5, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 2);
         applyStimulus(11'd5, 11'd6, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      end
`endif

      repeat (6) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/text_overlay_draw.md
Name: text_overlay_draw

Overview:
- Reads a 32x8 character grid from the text character ROM and rasterises it onto the VGA pixel stream as an 8x16-pixel-per-glyph overlay.
- The block drives the character-grid address `char_xy` and receives `char_code` one cycle later.
- It then drives the font-line address and receives one 8-pixel glyph row one cycle later.
- It sits in the VGA chain between the background/sprite stages and the output stage, and delays all timing signals to keep them aligned with `rgb_out`.

Parameters:
- X_POS, 11'd384, left pixel column of the text box.
- Y_POS, 11'd320, top pixel row of the text box.
- TEXT_COLOR, 12'hFFF, RGB444 colour of set glyph pixels.
- BLINK_PERIOD, 6'd30, frames per blink half-period (used only with TEXT_BLINK_EN).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  11  vertical line counter.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing inputs.
- rgb_in  in  12  upstream pixel colour.
- char_xy  out  8  grid address to character ROM: [7:3] = column, [2:0] = row.
- char_code  in  7  character code from character ROM, registered, 1-cycle latency.
- char_line_addr  out  11  font ROM address {char_code, glyph_row[3:0]}, combinational.
- char_line_pixels  in  8  font row from font ROM, registered, 1-cycle latency, bit 7 = leftmost pixel.
- hcount_out, vcount_out  out  11  inputs delayed 4 clocks.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  inputs delayed 4 clocks.
- rgb_out  out  12  composited pixel colour.

Behaviour:
- Reset:
  - All outputs and internal registers clear to 0 asynchronously on rst high.
  - First valid output appears 4 clocks after rst deasserts.
- Stage 1 (edge 1):
  - rel_x = hcount_in - X_POS and rel_y = vcount_in - Y_POS, both 11-bit wrap-around subtraction.
  - in_box = (X_POS <= hcount_in <= X_POS+255) && (Y_POS <= vcount_in <= Y_POS+127), using unsigned compares on the raw counters, not on rel.
  - Register char_xy <= {rel_x[7:3], rel_y[6:4]}.
  - Register rel_x[2:0], rel_y[3:0], in_box, and all timing/rgb inputs.
- Stage 2 (edge 2):
  - Character ROM presents char_code.
  - Block delays its metadata by one more stage.
  - char_line_addr = {char_code, rel_y_d2[3:0]}.
- Stage 3 (edge 3):
  - Font ROM presents char_line_pixels.
  - Metadata reaches d3.
- Stage 4 (edge 4):
  - pix = char_line_pixels[7 - rel_x_d3[2:0]].
  - rgb_out <= (in_box_d3 && pix && !hblnk_d3 && !vblnk_d3) ? TEXT_COLOR : rgb_d3.
  - All timing outputs <= d3 values.
- Total latency is exactly 4 clocks, input to every output, with no bubbles and no stall.
- Outside the box or during blanking: rgb passes through unchanged.
- Box edges:
  - Columns X_POS and X_POS+255 are inside; X_POS-1 and X_POS+256 are outside.
  - Rows Y_POS and Y_POS+127 are inside.
- Clipping: a box extending past the visible area is clipped implicitly; no wrap to column 0.
- Outside the box, char_xy still updates from the wrapped rel values; this is don't-care and is masked by in_box.
- Reset mid-frame: the pipeline flushes to 0. Stale ROM data is masked because in_box_d* is 0.

Optional Feature:
- Macro: TEXT_BLINK_EN.
- When defined:
  - An internal frame counter increments on each vsync_in rising edge, detected with a registered previous value.
  - At BLINK_PERIOD-1 the counter wraps to 0 and a `visible` flag toggles.
  - `visible` resets to 1 and the counter resets to 0.
  - Text is drawn only when `visible` = 1; otherwise rgb passes through.
  - `visible` is sampled alongside stage 1 and pipelined with in_box.
- When undefined: no counter logic; text is always drawn.

Test Plan:
- Latency/pass-through: ramp rgb_in and hcount outside the box → rgb_out and hcount_out equal the inputs exactly 4 clocks later; sync/blank signals are likewise delayed 4.
- Addressing: hcount=X_POS+17, vcount=Y_POS+35 → char_xy=8'h12 after 1 clock; with model ROM returning char_code=7'h52 → char_line_addr=11'h523.
- Pixel select: char_line_pixels=8'h80 → rgb_out=TEXT_COLOR at rel_x[2:0]=0 and =rgb_in at rel_x[2:0]=1..7. With 8'h01 → TEXT_COLOR only at rel_x[2:0]=7.
- Box edges with font row 8'hFF:
  - hcount=X_POS-1 and X_POS+256 → pass-through.
  - hcount=X_POS and X_POS+255 → TEXT_COLOR.
  - vcount=Y_POS+128 → pass-through.
  - In-box with hblnk=1 → pass-through.
- Async reset: assert rst mid-line between clock edges → all outputs read 0 before the next edge; after release, valid data appears exactly on the 4th edge.
- Blink (TEXT_BLINK_EN): 3 vsync pulses with BLINK_PERIOD=2 → text visible in frames 0-1, hidden in frame 2.
